imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer side of the instruction-memory read path used by the fetch stage.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words.
- Writes the words into the instruction memory write port at the addresses fetch reads: base + 2*i, because PC advances by 2 and indexes the ROM directly.
- Holds the CPU via cpu_hold until a complete, checksum-verified image is loaded.

Parameters:
- ADDR_W, 12, width of the instruction-memory address.
- BASE_ADDR, 0, address of the first word written.
- ADDR_STEP, 2, address increment per word. Matches the fetch PC step.
- MAX_WORDS, 2048, largest accepted word count.

Ports:
- clock  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that re-arms the loader from S_DONE or S_ERR.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_ready  out  1  loader accepts a byte; a transfer happens when in_valid & in_ready on a rising edge.
- wen  out  1  instruction-memory write enable, one-cycle pulse per word.
- waddr  out  ADDR_W  write address.
- wdata  out  16  write data.
- cpu_hold  out  1  high while no verified image is present; drives the CPU reset/hold.
- done  out  1  image loaded and checksum matched.
- error  out  1  length overflow or checksum mismatch.
- words_loaded  out  ADDR_W  count of words written since the last (re)start.

Behaviour:
- All outputs are registered except in_ready, which decodes from state.
- Reset (reset=0, asynchronous):
  - state=S_IDLE; wen=0; waddr=BASE_ADDR; wdata=0; words_loaded=0.
  - done=0; error=0; cpu_hold=1; internal length, index, hi-byte and XOR-accumulator all 0.
- States: S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM, S_DONE, S_ERR.
- in_ready=1 only in S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO and S_CSUM.
- S_IDLE: moves unconditionally to S_LEN_HI on the next edge. This guarantees in_ready=0 for at least one cycle after reset release.
- S_LEN_HI: on transfer, latch len[15:8] and go to S_LEN_LO.
- S_LEN_LO: on transfer, latch len[7:0], then:
  - if len > MAX_WORDS, go to S_ERR;
  - else if len == 0, go to S_CSUM;
  - else go to S_DATA_HI.
  - The full 16-bit compare uses the just-received byte.
- S_DATA_HI: on transfer, latch the hi byte, xor it into csum_acc, go to S_DATA_LO.
- S_DATA_LO: on transfer, xor the byte into csum_acc. The next edge produces:
  - wen=1, wdata={hi, byte}, waddr=BASE_ADDR+ADDR_STEP*index (truncated to ADDR_W);
  - index, words_loaded += 1;
  - next state S_CSUM if index+1 == len, else S_DATA_HI.
  - wen deasserts on the following edge.
  - Write latency: 1 cycle after the lo-byte transfer.
- S_CSUM: on transfer, go to S_DONE if the byte == csum_acc (XOR of all data bytes, length bytes excluded), else S_ERR.
- S_DONE: done=1, cpu_hold=0, error=0.
- S_ERR: error=1, cpu_hold=1, done=0. in_data is ignored and in_ready=0, so no bytes are consumed.
- start:
  - Honoured only in S_DONE and S_ERR.
  - On the next edge: state=S_LEN_HI; done=0; error=0; cpu_hold=1; index, words_loaded and csum_acc cleared; waddr=BASE_ADDR.
  - start in any other state is ignored.
- cpu_hold rises in the same edge that leaves S_DONE.
- in_valid low in any state: hold state, no side effects. Bubbles of any length are legal.
- in_data is don't-care when in_valid=0.
- Address arithmetic wraps modulo 2^ADDR_W. No error on wrap.
- Asynchronous reset mid-load:
  - Abandons the image and restores reset values immediately, regardless of clock.
  - Words already written stay in memory, but cpu_hold=1 until a new image completes.

Test Plan:
- Bytes 00 03 12 34 AB CD 00 01 41, in_valid held high:
  - writes (addr, data) = (0,0x1234), (2,0xABCD), (4,0x0001), one cycle apart per 2 bytes;
  - words_loaded=3; done=1 and cpu_hold=0 one edge after byte 41; error=0.
- Same stream with checksum 40 -> no done; error=1, cpu_hold=1, in_ready=0. Next start pulse -> in_ready=1, error=0, waddr=0.
- Bytes 00 00 00 -> no wen pulses; done=1, words_loaded=0.
- Bytes 08 01 -> error=1 immediately after the second byte; in_ready=0; further bytes not consumed.
- First stream with in_valid dropped for 3 cycles between every byte -> identical writes and final state; in_ready=1 throughout the gaps; no extra wen pulses.
- reset driven low asynchronously (between edges) right after the 0xABCD write:
  - wen=0, cpu_hold=1, done=0, waddr=0 immediately;
  - after release, in_ready=0 for one cycle, then 1;
  - a fresh full stream loads correctly.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte stream, assembles big-endian
// 16-bit instruction words, writes them to the instruction-memory write port
// at the fetch addresses, and releases the CPU only after the XOR checksum of
// the image matches.
`timescale 1ns / 1ps

module imem_loader #(
   parameter int ADDR_W    = 12,
   parameter int BASE_ADDR = 0,
   parameter int ADDR_STEP = 2,
   parameter int MAX_WORDS = 2048
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              wen,
   output logic [ADDR_W-1:0] waddr,
   output logic [15:0]       wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA_HI,
      S_DATA_LO,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_e;

   localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] STEP_A  = ADDR_W'(ADDR_STEP);
   localparam logic [15:0]       MAX_LEN = 16'(MAX_WORDS);

   state_e              state_q;
   logic [15:0]         len_q;
   logic [15:0]         index_q;
   logic [7:0]          hi_q;
   logic [7:0]          csum_q;
   logic                wen_q;
   logic [ADDR_W-1:0]   waddr_q;
   logic [15:0]         wdata_q;
   logic                hold_q;
   logic                done_q;
   logic                error_q;
   logic [ADDR_W-1:0]   words_q;

   logic                xfer;
   logic [15:0]         len_d;
   logic [ADDR_W-1:0]   addr_d;

   // Ready is a pure decode of the state so a stalled producer never loses a byte.
   // NOTE: continuous assigns cover every case, so no latch can be inferred here.
   assign in_ready = (state_q == S_LEN_HI)  || (state_q == S_LEN_LO) ||
                     (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                     (state_q == S_CSUM);

   assign xfer   = in_valid & in_ready;
   // Full length including the byte arriving this cycle, for the range check.
   assign len_d  = {len_q[15:8], in_data};
   // Fetch address of the word being completed; wraps modulo 2^ADDR_W.
   assign addr_d = BASE_A + STEP_A * ADDR_W'(index_q);

   assign wen          = wen_q;
   assign waddr        = waddr_q;
   assign wdata        = wdata_q;
   assign cpu_hold     = hold_q;
   assign done         = done_q;
   assign error        = error_q;
   assign words_loaded = words_q;

   // Loader FSM with all outputs registered; wen is a one-cycle pulse per word.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         index_q <= '0;
         hi_q    <= '0;
         csum_q  <= '0;
         wen_q   <= 1'b0;
         waddr_q <= BASE_A;
         wdata_q <= '0;
         hold_q  <= 1'b1;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         words_q <= '0;
      end else begin
         wen_q <= 1'b0;
         case (state_q)
            S_IDLE: state_q <= S_LEN_HI;

            S_LEN_HI: begin
               if (xfer) begin
                  len_q[15:8] <= in_data;
                  state_q     <= S_LEN_LO;
               end
            end

            S_LEN_LO: begin
               if (xfer) begin
                  len_q[7:0] <= in_data;
                  if (len_d > MAX_LEN) begin
                     state_q <= S_ERR;
                     error_q <= 1'b1;
                     done_q  <= 1'b0;
                     hold_q  <= 1'b1;
                  end else if (len_d == 16'd0) begin
                     state_q <= S_CSUM;
                  end else begin
                     state_q <= S_DATA_HI;
                  end
               end
            end

            S_DATA_HI: begin
               if (xfer) begin
                  hi_q    <= in_data;
                  csum_q  <= csum_q ^ in_data;
                  state_q <= S_DATA_LO;
               end
            end

            S_DATA_LO: begin
               if (xfer) begin
                  csum_q  <= csum_q ^ in_data;
                  wen_q   <= 1'b1;
                  wdata_q <= {hi_q, in_data};
                  waddr_q <= addr_d;
                  index_q <= index_q + 16'd1;
                  words_q <= words_q + ADDR_W'(1);
                  state_q <= (index_q + 16'd1 == len_q) ? S_CSUM : S_DATA_HI;
               end
            end

            S_CSUM: begin
               if (xfer) begin
                  if (in_data == csum_q) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     error_q <= 1'b0;
                     hold_q  <= 1'b0;
                  end else begin
                     state_q <= S_ERR;
                     error_q <= 1'b1;
                     done_q  <= 1'b0;
                     hold_q  <= 1'b1;
                  end
               end
            end

            S_DONE, S_ERR: begin
               if (start) begin
                  state_q <= S_LEN_HI;
                  done_q  <= 1'b0;
                  error_q <= 1'b0;
                  hold_q  <= 1'b1;
                  index_q <= '0;
                  words_q <= '0;
                  csum_q  <= '0;
                  waddr_q <= BASE_A;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
